wb_interconnect_1x4: RTL

// Single-master to four-slave Wishbone router: the fan-out counterpart of the

---
 rtl/wb_interconnect_1x4.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/wb_interconnect_1x4.sv
// rtl/wb_interconnect_1x4.sv - single-master to four-slave Wishbone address router
// Registered window decode, ERR for unmapped addresses, watchdog abort of stalled slaves.
module wb_interconnect_1x4 #(
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] SLAVE0_ADDR_BASE  = 'h0000_0000,
  parameter logic [WB_ADDR_WIDTH-1:0] SLAVE0_ADDR_LIMIT = 'h0000_FFFF,
  parameter logic [WB_ADDR_WIDTH-1:0] SLAVE1_ADDR_BASE  = 'h0001_0000,
  parameter logic [WB_ADDR_WIDTH-1:0] SLAVE1_ADDR_LIMIT = 'h0001_FFFF,
  parameter logic [WB_ADDR_WIDTH-1:0] SLAVE2_ADDR_BASE  = 'h0002_0000,
  parameter logic [WB_ADDR_WIDTH-1:0] SLAVE2_ADDR_LIMIT = 'h0002_FFFF,
  parameter logic [WB_ADDR_WIDTH-1:0] SLAVE3_ADDR_BASE  = 'h8000_0000,
  parameter logic [WB_ADDR_WIDTH-1:0] SLAVE3_ADDR_LIMIT = 'hFFFF_FFFF,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WB_ADDR_WIDTH-1:0]   m0_adr,
  input  logic [2:0]                 m0_cti,
  input  logic [1:0]                 m0_bte,
  input  logic [WB_DATA_WIDTH-1:0]   m0_dat_w,
  input  logic [WB_DATA_WIDTH/8-1:0] m0_sel,
  input  logic                       m0_cyc,
  input  logic                       m0_stb,
  input  logic                       m0_we,
  output logic [WB_DATA_WIDTH-1:0]   m0_dat_r,
  output logic                       m0_ack,
  output logic                       m0_err,
  output logic [WB_ADDR_WIDTH-1:0]   s_adr,
  output logic [2:0]                 s_cti,
  output logic [1:0]                 s_bte,
  output logic [WB_DATA_WIDTH-1:0]   s_dat_w,
  output logic [WB_DATA_WIDTH/8-1:0] s_sel,
  output logic                       s_we,
  output logic [3:0]                 s_cyc,
  output logic [3:0]                 s_stb,
  input  logic [WB_DATA_WIDTH-1:0]   s_dat_r [4],
  input  logic [3:0]                 s_ack,
  input  logic [3:0]                 s_err,
  output logic                       timeout
);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR_RSP} state_t;

  localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned WDOG_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LAST_I);
  localparam logic WDOG_ON = (TIMEOUT_CYCLES > 0);

  localparam logic [WB_ADDR_WIDTH-1:0] BASE [4] =
    '{SLAVE0_ADDR_BASE, SLAVE1_ADDR_BASE, SLAVE2_ADDR_BASE, SLAVE3_ADDR_BASE};
  localparam logic [WB_ADDR_WIDTH-1:0] LIMIT [4] =
    '{SLAVE0_ADDR_LIMIT, SLAVE1_ADDR_LIMIT, SLAVE2_ADDR_LIMIT, SLAVE3_ADDR_LIMIT};

  state_t            state, state_nxt;
  logic [1:0]        sel, sel_nxt;
  logic [WDOG_W-1:0] wdog, wdog_nxt;
  logic              timeout_nxt;
  logic              hit;
  logic [1:0]        hit_idx;
  logic              stall;
  logic              wdog_fire;

  // Offset-from-base test covers base<=adr<=limit in one unsigned compare;
  // scanning downwards leaves the lowest matching window selected.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if ((m0_adr - BASE[i]) <= (LIMIT[i] - BASE[i])) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  assign stall     = m0_stb && !s_ack[sel] && !s_err[sel];
  assign wdog_fire = WDOG_ON && stall && (wdog == WDOG_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      sel     <= 2'd0;
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      wdog    <= wdog_nxt;
      timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    wdog_nxt    = '0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (m0_cyc && m0_stb) begin
          if (hit) begin
            state_nxt = ACTIVE;
            sel_nxt   = hit_idx;
          end else begin
            state_nxt = ERR_RSP;
          end
        end
      end
      ACTIVE: begin
        if (!m0_cyc) begin
          state_nxt = IDLE;
        end else if (wdog_fire) begin
          state_nxt   = ERR_RSP;
          timeout_nxt = 1'b1;
        end else if (stall) begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      ERR_RSP: begin
        if (!m0_cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields fan out to every slave; only CYC/STB single out the target.
  assign s_adr   = m0_adr;
  assign s_cti   = m0_cti;
  assign s_bte   = m0_bte;
  assign s_dat_w = m0_dat_w;
  assign s_sel   = m0_sel;
  assign s_we    = m0_we;

  always_comb begin
    s_cyc    = '0;
    s_stb    = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_dat_r = '0;
    case (state)
      ACTIVE: begin
        s_cyc[sel] = m0_cyc;
        s_stb[sel] = m0_stb;
        m0_ack     = s_ack[sel];
        m0_err     = s_err[sel];
        m0_dat_r   = s_dat_r[sel];
      end
      ERR_RSP: m0_err = m0_stb;
      default: ;
    endcase
  end

endmodule
